// File: rtl/bin2bcd_seq_if.sv
// Handshake/result bundle for bin2bcd_seq. The blank vector exists only when
// BIN2BCD_SEQ_BLANK_EN is defined.
interface bin2bcd_seq_if #(
  parameter int W  = 16,
  parameter int ND = 5
);
  logic            start;
  logic [W-1:0]    bin;
  logic            busy;
  logic            done;
  logic [4*ND-1:0] bcd;
`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [ND-1:0]   blank;

  modport master (output start, bin, input busy, done, bcd, blank);
  modport slave  (input start, bin, output busy, done, bcd, blank);
`else
  modport master (output start, bin, input busy, done, bcd);
  modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative shift-add-3 binary-to-BCD converter: one digit-correction step per clock.
// Optional macro BIN2BCD_SEQ_BLANK_EN adds a registered leading-zero blank vector.
module bin2bcd_seq_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module bin2bcd_seq #(
  parameter int W  = 16,
  parameter int ND = 5
) (
  input  logic          clk,
  input  logic          reset,
  bin2bcd_seq_if.slave  io
);
  localparam int SRW = 4*ND + W;
  localparam int CW  = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  if ((64'd10 ** ND) <= ((64'd1 << W) - 64'd1)) begin : g_nd_chk
    $error("bin2bcd_seq: ND digits cannot hold 2^W-1");
  end

  typedef enum logic {IDLE, CONV} state_t;

  state_t          state_q, state_d;
  logic [SRW-1:0]  sr_q, sr_next;
  logic [CW-1:0]   cnt_q;
  logic [4*ND-1:0] bcd_q, acc_corr, new_bcd;
  logic            done_q;
  logic            load, step, last;

  // Correct every digit in parallel; digits never carry into each other.
  for (genvar i = 0; i < ND; i++) begin : g_dig
    bin2bcd_seq_add3 u_add3 (.d(sr_q[W + 4*i +: 4]), .q(acc_corr[4*i +: 4]));
  end

  assign sr_next = {acc_corr[4*ND-2:0], sr_q[W-1:0], 1'b0};
  assign new_bcd = sr_next[SRW-1:W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: if (io.start) begin
        state_d = CONV;
        load    = 1'b1;
      end
      CONV: begin
        step = 1'b1;
        if (cnt_q == LAST) begin
          last    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      done_q <= 1'b0;
    end else begin
      if (load) begin
        sr_q  <= {{(4*ND){1'b0}}, io.bin};
        cnt_q <= '0;
      end else if (step) begin
        sr_q  <= sr_next;
        cnt_q <= cnt_q + 1'b1;
      end
      done_q <= last;
      if (last) bcd_q <= new_bcd;
    end
  end

  assign io.busy = (state_q == CONV);
  assign io.done = done_q;
  assign io.bcd  = bcd_q;

`ifdef BIN2BCD_SEQ_BLANK_EN
  logic [ND-1:0] blank_d, blank_q;

  // A digit blanks only if it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic z;
    blank_d = '0;
    z       = 1'b1;
    for (int i = ND-1; i >= 1; i--) begin
      z          = z & (new_bcd[4*i +: 4] == 4'd0);
      blank_d[i] = z;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    blank_q <= {ND{1'b1}} << 1;
    else if (last) blank_q <= blank_d;
  end

  assign io.blank = blank_q;
`endif
endmodule
